// File: rtl/datapath_arbiter8_pkg.sv
// rtl/datapath_arbiter8_pkg.sv - shared constants and types for the datapath arbiter
//
// Purpose : requester count, index width, FSM state encoding and the
//           rotation mask helper used by datapath_arbiter8.
// Ports   : none (package).
package datapath_arbiter8_pkg;

   localparam int NREQ  = 8;
   localparam int IDX_W = $clog2(NREQ);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Bits strictly below idx; these requesters come first in the next rotation.
   function automatic logic [NREQ-1:0] below_mask(input logic [IDX_W-1:0] idx);
      return (NREQ'(1) << idx) - NREQ'(1);
   endfunction

endpackage

// File: rtl/datapath_arbiter8_penc.sv
// rtl/datapath_arbiter8_penc.sv - priority encoder, highest set bit wins
//
// Purpose : returns the index of the highest set bit of req_vec.
//           Returns 0 both for "bit 0 set" and "nothing set"; callers
//           qualify with their own non-zero test.
// Ports   : enable  - when low, idx is forced to 0
//           req_vec - request vector (W bits)
//           idx     - index of highest set bit (IW bits)
module priority_encoder
   import datapath_arbiter8_pkg::*;
#(
   parameter int W  = NREQ,
   parameter int IW = $clog2(W)
) (
   input  logic          enable,
   input  logic [W-1:0]  req_vec,
   output logic [IW-1:0] idx
);

   // Ascending scan: the last hit is the highest set bit.
   always_comb begin
      idx = '0;
      if (enable) begin
         for (int i = 0; i < W; i++) begin
            if (req_vec[i]) begin
               idx = IW'(i);
            end
         end
      end
   end

endmodule

// File: rtl/datapath_arbiter8.sv
// rtl/datapath_arbiter8.sv - 8-way round-robin arbiter for a shared datapath
//
// Purpose : grants one of 8 requesters at a time, holds the grant while the
//           owner keeps requesting, preempts after MAX_HOLD cycles
//           (0 = never) and always leaves one idle cycle between grants.
// Ports   : clk         - rising-edge clock
//           reset       - synchronous active-high reset
//           enable      - gates new grants only; a running grant continues
//           req[7:0]    - level requests, held for the whole transaction
//           grant[7:0]  - registered one-hot grant
//           grant_idx   - registered owner index, datapath mux select
//           grant_valid - |grant
//           timeout     - one-cycle pulse when the owner is preempted
//           timeout_idx - preempted owner, valid while timeout=1
module datapath_arbiter8
   import datapath_arbiter8_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [NREQ-1:0]  req,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid,
   output logic             timeout,
   output logic [IDX_W-1:0] timeout_idx
);

   localparam bit               HOLD_EN   = (MAX_HOLD != 0);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

   state_t             state;
   logic [IDX_W-1:0]   last_idx;
   logic [CNT_W-1:0]   hold_cnt;
   logic [NREQ-1:0]    masked;
   logic [IDX_W-1:0]   w_masked;
   logic [IDX_W-1:0]   w_raw;
   logic [IDX_W-1:0]   winner;

   // Requesters below the previous owner are searched first (highest first);
   // if none, fall back to the full vector, which puts the previous owner last.
   assign masked = req & below_mask(last_idx);

   priority_encoder #(.W(NREQ), .IW(IDX_W)) u_penc_masked (
      .enable  (1'b1),
      .req_vec (masked),
      .idx     (w_masked)
   );

   priority_encoder #(.W(NREQ), .IW(IDX_W)) u_penc_raw (
      .enable  (1'b1),
      .req_vec (req),
      .idx     (w_raw)
   );

   assign winner      = (masked != '0) ? w_masked : w_raw;
   assign grant_valid = |grant;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         grant       <= '0;
         grant_idx   <= '0;
         last_idx    <= '0;
         hold_cnt    <= '0;
         timeout     <= 1'b0;
         timeout_idx <= '0;
      end else begin
         timeout     <= 1'b0;
         timeout_idx <= '0;
         case (state)
            ST_IDLE: begin
               if (enable && (req != '0)) begin
                  grant     <= NREQ'(1) << winner;
                  grant_idx <= winner;
                  last_idx  <= winner;
                  hold_cnt  <= '0;
                  state     <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // Release is checked first so a release on the last allowed
               // cycle never raises a timeout pulse.
               if (!req[grant_idx]) begin
                  grant     <= '0;
                  grant_idx <= '0;
                  state     <= ST_IDLE;
               end else if (HOLD_EN && (hold_cnt == HOLD_LAST)) begin
                  grant       <= '0;
                  grant_idx   <= '0;
                  state       <= ST_IDLE;
                  timeout     <= 1'b1;
                  timeout_idx <= grant_idx;
               end else if (HOLD_EN) begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_datapath_arbiter8.sv
// tb/tb_datapath_arbiter8.sv - scoreboard bench for datapath_arbiter8
module tb_datapath_arbiter8;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       timeout;
   logic [2:0] timeout_idx;

   datapath_arbiter8 #(.MAX_HOLD(4), .CNT_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .req         (req),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .timeout     (timeout),
      .timeout_idx (timeout_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int idx;
      int len;
      int gap;   // idle cycles before this grant, -1 = not checked
   } rec_t;

   rec_t sb[$];
   int   tq[$];
   int   total = 0;
   int   bad   = 0;
   bit   done  = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int idx, input int len, input int gap);
      rec_t r;
      r.idx = idx;
      r.len = len;
      r.gap = gap;
      sb.push_back(r);
   endtask

   // Returns at the first negedge of a fresh grant.
   task automatic wait_new_grant(input string name);
      int n = 0;
      while (grant_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      while (!grant_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         total++;
         bad++;
         $display("FAIL %s: no new grant within 100 cycles", name);
      end
   endtask

   // Monitor: invariants every cycle, grant/timeout events against the queues.
   initial begin
      bit   prev_valid = 1'b0;
      int   run_len    = 0;
      int   gap_len    = 0;
      rec_t cur;
      cur.idx = 0; cur.len = 0; cur.gap = -1;
      forever begin
         @(negedge clk);
         if (!done) begin
            chk("grant_valid_or", int'(grant_valid), int'(|grant));
            chk("grant_onehot0", int'($countones(grant) <= 1), 1);
            if (grant_valid)
               chk("grant_vs_idx", int'(grant), int'(8'(1) << grant_idx));
            else
               chk("idle_idx_zero", int'(grant_idx), 0);

            if (grant_valid && !prev_valid) begin
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_grant: idx=%0d with nothing expected", grant_idx);
                  cur.idx = -1; cur.len = -1; cur.gap = -1;
               end else begin
                  cur = sb.pop_front();
                  chk("grant_idx", int'(grant_idx), cur.idx);
                  if (cur.gap >= 0) chk("idle_gap", gap_len, cur.gap);
               end
               run_len = 1;
            end else if (grant_valid) begin
               run_len++;
            end else if (prev_valid) begin
               if (cur.len >= 0) chk("grant_len", run_len, cur.len);
               gap_len = 1;
            end else begin
               gap_len++;
            end

            if (timeout) begin
               chk("timeout_while_idle", int'(grant_valid), 0);
               if (tq.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_timeout: idx=%0d with nothing expected", timeout_idx);
               end else begin
                  chk("timeout_idx", int'(timeout_idx), tq.pop_front());
               end
            end
            prev_valid = grant_valid;
         end
      end
   end

   initial begin
      int order[8] = '{2, 1, 0, 7, 6, 5, 4, 3};
      int tcnt;

      // 1: reset with all requesting, then fixed priority gives idx 7
      reset  = 1'b1;
      enable = 1'b1;
      req    = 8'hFF;
      repeat (2) begin
         @(negedge clk);
         chk("rst_grant", int'(grant), 0);
         chk("rst_timeout", int'(timeout), 0);
         chk("rst_timeout_idx", int'(timeout_idx), 0);
      end
      push(7, 1, -1);
      reset = 1'b0;
      @(negedge clk);
      chk("first_grant_vec", int'(grant), 8'h80);
      chk("first_grant_idx", int'(grant_idx), 7);
      req = 8'h00;
      repeat (3) @(negedge clk);

      // 2: req 0A, idx 3 for 3 cycles, one idle cycle, then idx 1
      push(3, 3, -1);
      push(1, 2, 1);
      req = 8'h0A;
      wait_new_grant("t2_first");
      repeat (2) @(negedge clk);
      req = 8'h02;
      wait_new_grant("t2_second");
      @(negedge clk);
      req = 8'h00;
      repeat (3) @(negedge clk);

      // 3: last_idx=3 then full contention rotates 2,1,0,7,6,5,4,3
      push(3, 1, -1);
      req = 8'h08;
      wait_new_grant("t3_setup");
      req = 8'h00;
      @(negedge clk);
      for (int k = 0; k < 8; k++) push(order[k], 1, 1);
      req = 8'hFF;
      for (int k = 0; k < 8; k++) begin
         wait_new_grant("t3_rotation");
         req = 8'hFF & ~(8'(1) << order[k]);
         @(negedge clk);
         req = (k == 7) ? 8'h00 : 8'hFF;
      end
      repeat (3) @(negedge clk);

      // 5: enable gates new grants only; other requests ignored while busy
      enable = 1'b0;
      req    = 8'h10;
      repeat (4) begin
         @(negedge clk);
         chk("enable_low_no_grant", int'(grant_valid), 0);
      end
      push(4, 3, -1);
      enable = 1'b1;
      wait_new_grant("t5_grant");
      enable = 1'b0;
      req    = 8'h90;
      repeat (2) @(negedge clk);
      req = 8'h80;
      @(negedge clk);
      repeat (4) begin
         @(negedge clk);
         chk("enable_low_after_release", int'(grant_valid), 0);
      end
      req    = 8'h00;
      enable = 1'b1;
      repeat (2) @(negedge clk);

      // 6: reset on 2nd grant cycle drops grant, no timeout, last_idx cleared
      push(3, 2, -1);
      push(7, 1, -1);
      req = 8'h08;
      wait_new_grant("t6_grant");
      @(negedge clk);
      reset = 1'b1;
      req   = 8'h82;
      @(negedge clk);
      chk("midgrant_reset_grant", int'(grant), 0);
      chk("midgrant_reset_timeout", int'(timeout), 0);
      reset = 1'b0;
      wait_new_grant("t6_after_reset");
      req = 8'h00;
      repeat (3) @(negedge clk);

      // 4: MAX_HOLD=4, req 21 held: 5, timeout, 0, timeout, 5, timeout
      push(5, 4, -1);
      push(0, 4, 1);
      push(5, 4, 1);
      tq.push_back(5);
      tq.push_back(0);
      tq.push_back(5);
      req  = 8'h21;
      tcnt = 0;
      for (int n = 0; n < 200 && tcnt < 3; n++) begin
         @(negedge clk);
         if (timeout) tcnt++;
      end
      chk("t4_timeouts_seen", tcnt, 3);
      req = 8'h00;
      repeat (3) @(negedge clk);

      // 7: release on the last allowed cycle wins over timeout
      push(6, 4, -1);
      req = 8'h40;
      wait_new_grant("t7_grant");
      repeat (3) @(negedge clk);
      req = 8'h00;
      repeat (4) @(negedge clk);

      done = 1'b1;
      chk("sb_grants_left", sb.size(), 0);
      chk("sb_timeouts_left", tq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/datapath_arbiter8.md
Name: datapath_arbiter8

Overview:
- Round-robin arbiter that shares one combinational datapath (adder/comparator behind an 8-way mux) among 8 requesters.
- Grants one requester at a time and holds the grant while that requester keeps its request asserted.
- Enforces a maximum hold time, with forced preemption when it expires.
- grant_idx drives the crtl input of the 8-way datapath input mux directly.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one owner may hold the grant. 0 disables the timeout.
- CNT_W, 8: width of the hold counter. MAX_HOLD must be < 2^CNT_W.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  when low, no new grant is issued; an existing grant continues
- req  input  8  level request per requester; held high for the whole transaction
- grant  output  8  one-hot grant, registered
- grant_idx  output  3  binary index of owner, registered; mux select
- grant_valid  output  1  high while any grant is active (equals |grant)
- timeout  output  1  one-cycle pulse when the owner is preempted
- timeout_idx  output  3  index of the preempted owner; valid while timeout=1

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - grant=0, grant_idx=0, grant_valid=0, timeout=0, timeout_idx=0
  - state=IDLE, last_idx=0, hold_cnt=0
- Reset asserted mid-grant: the grant drops at that clock edge. No timeout pulse is generated.
- State machine has two states, IDLE and BUSY.
- IDLE:
  - If enable=1 and req!=0, pick a winner w. On the next edge: grant=1<<w, grant_idx=w, last_idx=w, hold_cnt=0, go to BUSY.
  - Latency from req to grant is 1 cycle.
  - Otherwise stay in IDLE with all outputs 0.
- Winner selection (round-robin built on a priority encoder where the highest index wins):
  - masked = req & ((1<<last_idx)-1).
  - If masked!=0, w = highest set bit of masked; else w = highest set bit of req.
  - Effective search order: last_idx-1 down to 0, then 7 down to last_idx.
  - After reset (last_idx=0) this is pure fixed priority, 7 highest.
- BUSY, normal path:
  - If req[grant_idx]=0, release: on the next edge grant=0, grant_valid=0, go to IDLE.
  - Otherwise hold_cnt increments by 1 per cycle.
- BUSY, timeout path (MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, req[grant_idx] still 1):
  - On the next edge: grant=0, go to IDLE, timeout=1 for exactly one cycle, timeout_idx=previous owner.
  - The preempted owner is lowest priority in the next arbitration by the rotation rule.
- Grant lengths:
  - An owner holds the grant for at most MAX_HOLD cycles.
  - At least 1 idle cycle (grant=0) separates consecutive grants. This gives a guaranteed datapath turnaround.
- Boundaries:
  - Requests from non-owners during BUSY are ignored. No preemption except by timeout.
  - enable falling during BUSY has no effect on the current owner. enable only gates IDLE→BUSY.
  - Release and timeout in the same cycle: release wins and no timeout pulse is raised.
  - A single requester held high permanently with MAX_HOLD=16 cycles through: 16 granted cycles, 1 idle cycle with a timeout pulse, then regranted.
  - hold_cnt never wraps. It saturates at MAX_HOLD-1 by construction; with MAX_HOLD=0 the counter is frozen at 0.
  - grant is always one-hot or zero. grant_valid == |grant at all times.

Decomposition:
- Shared defines file: state encodings (ST_IDLE=1'b0, ST_BUSY=1'b1) and the requester count constant NREQ=8.
- Reuse the existing priority_encoder module twice, with enable=1:
  - one instance on masked requests
  - one instance on raw requests
- Select between them with masked!=0.
- Note: the encoder cannot distinguish "bit 0 set" from "no bits set". The arbiter qualifies with req!=0 / masked!=0 itself.
- No other sub-module. The FSM, counter and rotation register live in datapath_arbiter8.

Test Plan:
1. reset=1 for 2 cycles with req=8'hFF → grant=0, grant_valid=0, timeout=0 throughout. After reset drops, grant=8'h80 and grant_idx=7 one cycle later.
2. req=8'h0A held; owner drops its req after 3 cycles → grant 8'h08 (idx 3) for 3 cycles, 1 idle cycle, then grant 8'h02 (idx 1).
3. Fairness: last_idx=3 with req=8'hFF, each owner releasing after 1 cycle → grant order idx 2,1,0,7,6,5,4,3, each separated by 1 idle cycle.
4. Timeout: MAX_HOLD=4, req=8'h21 held → idx5 granted 4 cycles, then timeout=1 with timeout_idx=5, then idx0 granted 4 cycles, then idx5 again.
5. enable=0 while req=8'h10 → no grant. enable drops during an active grant → the grant persists until release.
6. Reset asserted on the 2nd cycle of a grant → grant=0 at that edge, no timeout pulse, last_idx=0. The next arbitration gives fixed priority 7 first.
